// File: rtl/pingpong_input_buffer_pkg.sv
// ============================================================================
// input_buffer_pkg : shared types and helpers for the ping-pong input buffer
// Revision: 1.0
// ============================================================================
`default_nettype none

package input_buffer_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_t;

  localparam int NUM_BANKS = 2;

  // A zero or oversized fill request means "fill the whole bank".
  function automatic int clamp_len(input int len, input int depth);
    return ((len == 0) || (len > depth)) ? depth : len;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pingpong_input_buffer_bank.sv
// ============================================================================
// buffer_bank : simple dual-port RAM, synchronous write, registered read
// Revision: 1.0
// ============================================================================
`default_nettype none

module buffer_bank #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     i_wr_en,
  input  logic [ADDR_W-1:0]        i_wr_addr,
  input  logic signed [DATA_W-1:0] i_wr_data,
  input  logic                     i_rd_en,
  input  logic [ADDR_W-1:0]        i_rd_addr,
  output logic signed [DATA_W-1:0] o_rd_data
);

  logic signed [DATA_W-1:0] r_mem [DEPTH];
  logic signed [DATA_W-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/pingpong_input_buffer.sv
// ============================================================================
// pingpong_input_buffer : two-bank input buffer, producer fills one bank while
// the consumer randomly reads the other.  Revision: 1.0
// ============================================================================
`default_nettype none

module pingpong_input_buffer
  import input_buffer_pkg::*;
#(
  parameter int  BUFFER_DATA_WIDTH = 16,
  parameter int  DEPTH             = 64,
  localparam int BUF_ADDR_W        = $clog2(DEPTH)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [BUF_ADDR_W:0]                 fill_len,
  input  logic                                wr_valid,
  output logic                                wr_ready,
  input  logic signed [BUFFER_DATA_WIDTH-1:0] wr_data,
  output logic                                bank_filled,
  output logic                                rd_bank_ready,
  output logic [BUF_ADDR_W:0]                 rd_len,
  input  logic                                rd_en,
  input  logic [BUF_ADDR_W-1:0]               rd_addr,
  output logic signed [BUFFER_DATA_WIDTH-1:0] rd_data,
  output logic                                rd_valid,
  input  logic                                rd_release,
  output logic                                rd_err
);

  localparam int LEN_W = BUF_ADDR_W + 1;

  bank_state_t                     r_state   [NUM_BANKS];
  logic [LEN_W-1:0]                r_len     [NUM_BANKS];
  logic [LEN_W-1:0]                r_cur_len;
  logic [BUF_ADDR_W-1:0]           r_wr_ptr;
  logic                            r_wr_bank;
  logic                            r_rd_bank;
  logic                            r_wr_ready;
  logic                            r_rd_bank_ready;
  logic [LEN_W-1:0]                r_rd_len;
  logic                            r_bank_filled;
  logic                            r_rd_valid;
  logic                            r_rd_err;
  logic                            r_rd_sel;
  logic signed [BUFFER_DATA_WIDTH-1:0] r_rd_hold;

  bank_state_t                     w_state_n [NUM_BANKS];
  logic [LEN_W-1:0]                w_len_n   [NUM_BANKS];
  logic [LEN_W-1:0]                w_cur_len_n;
  logic [BUF_ADDR_W-1:0]           w_wr_ptr_n;
  logic                            w_wr_bank_n;
  logic                            w_rd_bank_n;
  logic [LEN_W-1:0]                w_len_clamp;
  logic [LEN_W-1:0]                w_len_eff;
  logic                            w_wr_acc;
  logic                            w_wr_last;
  logic                            w_rd_acc;
  logic                            w_release;
  logic signed [BUFFER_DATA_WIDTH-1:0] w_bank_q [NUM_BANKS];

  always_comb begin : p_handshake
    w_len_clamp = LEN_W'(clamp_len(int'(fill_len), DEPTH));
    // The first word of a bank uses the freshly sampled length.
    w_len_eff   = (r_state[r_wr_bank] == BANK_EMPTY) ? w_len_clamp : r_cur_len;
    w_wr_acc    = wr_valid & r_wr_ready;
    w_wr_last   = ({1'b0, r_wr_ptr} == (w_len_eff - LEN_W'(1)));
    w_rd_acc    = rd_en & r_rd_bank_ready & ({1'b0, rd_addr} < r_rd_len);
    w_release   = rd_release & r_rd_bank_ready;
  end

  always_comb begin : p_next
    w_state_n   = r_state;
    w_len_n     = r_len;
    w_cur_len_n = r_cur_len;
    w_wr_ptr_n  = r_wr_ptr;
    w_wr_bank_n = r_wr_bank;
    w_rd_bank_n = r_rd_bank;
    if (w_wr_acc) begin
      w_cur_len_n = w_len_eff;
      if (w_wr_last) begin
        w_state_n[r_wr_bank] = BANK_FULL;
        w_len_n[r_wr_bank]   = w_len_eff;
        w_wr_ptr_n           = '0;
        w_wr_bank_n          = ~r_wr_bank;
      end else begin
        w_state_n[r_wr_bank] = BANK_FILLING;
        w_wr_ptr_n           = r_wr_ptr + BUF_ADDR_W'(1);
      end
    end
    // A release only ever targets a FULL bank, never the one being written.
    if (w_release) begin
      w_state_n[r_rd_bank] = BANK_EMPTY;
      w_rd_bank_n          = ~r_rd_bank;
    end
  end

  always_ff @(posedge clk or posedge rst) begin : p_state
    if (rst) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        r_state[i] <= BANK_EMPTY;
        r_len[i]   <= '0;
      end
      r_cur_len       <= '0;
      r_wr_ptr        <= '0;
      r_wr_bank       <= 1'b0;
      r_rd_bank       <= 1'b0;
      r_wr_ready      <= 1'b0;
      r_rd_bank_ready <= 1'b0;
      r_rd_len        <= '0;
      r_bank_filled   <= 1'b0;
      r_rd_valid      <= 1'b0;
      r_rd_err        <= 1'b0;
      r_rd_sel        <= 1'b0;
      r_rd_hold       <= '0;
    end else begin
      r_state         <= w_state_n;
      r_len           <= w_len_n;
      r_cur_len       <= w_cur_len_n;
      r_wr_ptr        <= w_wr_ptr_n;
      r_wr_bank       <= w_wr_bank_n;
      r_rd_bank       <= w_rd_bank_n;
      r_wr_ready      <= (w_state_n[w_wr_bank_n] != BANK_FULL);
      r_rd_bank_ready <= (w_state_n[w_rd_bank_n] == BANK_FULL);
      r_rd_len        <= (w_state_n[w_rd_bank_n] == BANK_FULL) ? w_len_n[w_rd_bank_n] : '0;
      r_bank_filled   <= w_wr_acc & w_wr_last;
      r_rd_valid      <= w_rd_acc;
      r_rd_err        <= rd_en & ~w_rd_acc;
      r_rd_hold       <= rd_data;
      if (w_rd_acc) r_rd_sel <= r_rd_bank;
    end
  end

  always_comb begin : p_outputs
    wr_ready      = r_wr_ready;
    bank_filled   = r_bank_filled;
    rd_bank_ready = r_rd_bank_ready;
    rd_len        = r_rd_len;
    rd_valid      = r_rd_valid;
    rd_err        = r_rd_err;
    rd_data       = r_rd_valid ? w_bank_q[r_rd_sel] : r_rd_hold;
  end

  generate
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      buffer_bank #(
        .DATA_W (BUFFER_DATA_WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (BUF_ADDR_W)
      ) u_bank (
        .clk       (clk),
        .i_wr_en   (w_wr_acc & (r_wr_bank == 1'(gi))),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (wr_data),
        .i_rd_en   (w_rd_acc & (r_rd_bank == 1'(gi))),
        .i_rd_addr (rd_addr),
        .o_rd_data (w_bank_q[gi])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_pingpong_input_buffer.sv
// ============================================================================
// tb_pingpong_input_buffer : directed scoreboard bench for the ping-pong buffer
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pingpong_input_buffer;

  localparam int W     = 16;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [AW:0]         fill_len = '0;
  logic                wr_valid = 1'b0;
  logic                wr_ready;
  logic signed [W-1:0] wr_data = '0;
  logic                bank_filled;
  logic                rd_bank_ready;
  logic [AW:0]         rd_len;
  logic                rd_en = 1'b0;
  logic [AW-1:0]       rd_addr = '0;
  logic signed [W-1:0] rd_data;
  logic                rd_valid;
  logic                rd_release = 1'b0;
  logic                rd_err;

  pingpong_input_buffer #(.BUFFER_DATA_WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .fill_len(fill_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .bank_filled(bank_filled), .rd_bank_ready(rd_bank_ready), .rd_len(rd_len),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_release(rd_release), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic signed [W-1:0] sb [$];
  logic signed [W-1:0] mem [2][DEPTH];
  int blen [2];
  int tb_wb = 0, tb_rb = 0, tb_ptr = 0, tb_len = 0;
  logic signed [W-1:0] q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(negedge clk);
    if (rd_valid) begin
      if (sb.size() == 0) chk("rd_valid_spurious", 32'(rd_valid), 32'd0);
      else chk("rd_data", 32'(rd_data), 32'(sb.pop_front()));
    end
  endtask

  task automatic fill(input int flen, input bit rel_last);
    int  n;
    bit  done;
    fill_len = (AW+1)'(flen);
    for (int i = 0; i < q.size(); i++) begin
      n = 0;
      while (!wr_ready && n < 200) begin cyc(); n++; end
      chk("wr_ready_wait", 32'(wr_ready), 32'd1);
      if (tb_ptr == 0) tb_len = (flen == 0 || flen > DEPTH) ? DEPTH : flen;
      wr_valid = 1'b1;
      wr_data  = q[i];
      mem[tb_wb][tb_ptr] = q[i];
      done = (tb_ptr + 1 == tb_len);
      if (rel_last && i == q.size() - 1) rd_release = 1'b1;
      cyc();
      wr_valid   = 1'b0;
      rd_release = 1'b0;
      chk("bank_filled", 32'(bank_filled), 32'(done));
      if (done) begin blen[tb_wb] = tb_len; tb_wb ^= 1; tb_ptr = 0; end
      else tb_ptr++;
      if (rel_last && i == q.size() - 1) tb_rb ^= 1;
    end
  endtask

  task automatic rnd(input int n);
    q.delete();
    for (int i = 0; i < n; i++) q.push_back(W'($urandom));
  endtask

  task automatic rd(input int addr, input bit ok);
    logic signed [W-1:0] prev;
    prev    = rd_data;
    rd_en   = 1'b1;
    rd_addr = AW'(addr);
    if (ok) sb.push_back(mem[tb_rb][addr]);
    cyc();
    rd_en = 1'b0;
    chk("rd_valid", 32'(rd_valid), 32'(ok));
    chk("rd_err", 32'(rd_err), 32'(!ok));
    if (!ok) chk("rd_data_hold", 32'(rd_data), 32'(prev));
  endtask

  task automatic release_bank();
    rd_release = 1'b1;
    cyc();
    rd_release = 1'b0;
    tb_rb ^= 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst = 1'b1;
    cyc(); cyc();
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_rd_bank_ready", 32'(rd_bank_ready), 32'd0);
    chk("rst_rd_len", 32'(rd_len), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_bank_filled", 32'(bank_filled), 32'd0);
    chk("rst_rd_err", 32'(rd_err), 32'd0);
    rst = 1'b0;
    cyc();
    chk("post_rst_wr_ready", 32'(wr_ready), 32'd1);

    // Illegal read with no ready bank
    rd(0, 1'b0);

    // Basic fill and readback
    q.delete();
    q.push_back(16'sd10); q.push_back(-16'sd3); q.push_back(16'sd7); q.push_back(16'sd127);
    fill(4, 1'b0);
    chk("t1_rd_bank_ready", 32'(rd_bank_ready), 32'd1);
    chk("t1_rd_len", 32'(rd_len), 32'd4);
    for (int a = 0; a < 4; a++) rd(a, 1'b1);
    chk("t1_bank_filled_once", 32'(bank_filled), 32'd0);
    rd(5, 1'b0);
    rd(4, 1'b0);

    // Both banks full: writer stalls until a release
    rnd(4);
    fill(4, 1'b0);
    chk("t2_wr_ready_blocked", 32'(wr_ready), 32'd0);
    cyc();
    chk("t2_wr_ready_still_blocked", 32'(wr_ready), 32'd0);
    release_bank();
    chk("t2_wr_ready_after_release", 32'(wr_ready), 32'd1);
    chk("t2_rd_bank_ready", 32'(rd_bank_ready), 32'd1);
    chk("t2_rd_len", 32'(rd_len), 32'd4);
    for (int a = 0; a < 4; a++) rd(a, 1'b1);

    // fill_len of 0 clamps to the full depth
    rnd(DEPTH);
    fill(0, 1'b0);
    chk("t3_wr_ready_blocked", 32'(wr_ready), 32'd0);
    release_bank();
    chk("t3_rd_len", 32'(rd_len), 32'(DEPTH));
    rd(0, 1'b1); rd(63, 1'b1); rd(17, 1'b1);

    // Release of bank0 coincides with bank1 fill completion
    rnd(4);
    fill(4, 1'b1);
    chk("t5_rd_bank_ready", 32'(rd_bank_ready), 32'd1);
    chk("t5_rd_len", 32'(rd_len), 32'd4);
    chk("t5_wr_ready", 32'(wr_ready), 32'd1);
    for (int a = 0; a < 4; a++) rd(a, 1'b1);
    rnd(3);
    fill(3, 1'b0);
    release_bank();
    chk("t5_refill_rd_len", 32'(rd_len), 32'd3);
    rd(2, 1'b1);
    rd(3, 1'b0);

    // Reset mid-fill and mid-read aborts everything
    rnd(2);
    fill(4, 1'b0);
    rd_en   = 1'b1;
    rd_addr = AW'(1);
    sb.push_back(mem[tb_rb][1]);
    cyc();
    rd_en = 1'b0;
    chk("t6_rd_valid_pre", 32'(rd_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_wr_ready", 32'(wr_ready), 32'd0);
    chk("t6_rd_bank_ready", 32'(rd_bank_ready), 32'd0);
    chk("t6_rd_valid", 32'(rd_valid), 32'd0);
    chk("t6_rd_data", 32'(rd_data), 32'd0);
    tb_wb = 0; tb_rb = 0; tb_ptr = 0;
    cyc();
    rst = 1'b0;
    cyc();
    chk("t6_no_bank_filled", 32'(bank_filled), 32'd0);
    chk("t6_wr_ready_up", 32'(wr_ready), 32'd1);
    rnd(4);
    fill(4, 1'b0);
    chk("t6_rd_bank_ready_up", 32'(rd_bank_ready), 32'd1);
    chk("t6_rd_len", 32'(rd_len), 32'd4);
    for (int a = 0; a < 4; a++) rd(a, 1'b1);
    cyc();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pingpong_input_buffer.md
Name: pingpong_input_buffer

Overview:
- Double-buffered (ping-pong) input buffer for the accelerator datapath: a producer streams words into one bank while the compute engine randomly reads a previously filled bank.
- Replaces single-bank read/write collision handling: a bank is never read and written in the same phase, so no read-during-write hazard exists.
- Sits between the input DMA/stream source and the PE array operand fetch.

Parameters:
- BUFFER_DATA_WIDTH, DATA_WIDTH (GLOBAL_PARAMS.vh), width of each stored signed word.
- DEPTH, 64, words per bank; must be ≥2.
- BUF_ADDR_W, $clog2(DEPTH), address width; derived, not overridden.

Ports:
- clk  in  1  system clock, posedge.
- rst  in  1  asynchronous active-high reset.
- fill_len  in  BUF_ADDR_W+1  words per fill; sampled on the first accepted write of a bank.
- wr_valid  in  1  producer word valid.
- wr_ready  out  1  buffer can accept a word this cycle.
- wr_data  in  BUFFER_DATA_WIDTH  signed word to store.
- bank_filled  out  1  one-cycle pulse when a bank completes filling.
- rd_bank_ready  out  1  a FULL bank is available for reading.
- rd_len  out  BUF_ADDR_W+1  captured fill length of the current read bank.
- rd_en  in  1  read request.
- rd_addr  in  BUF_ADDR_W  read address within the read bank.
- rd_data  out  BUFFER_DATA_WIDTH  registered read data.
- rd_valid  out  1  rd_data is valid; asserted one cycle after an accepted read.
- rd_release  in  1  consumer done with the read bank; frees it.
- rd_err  out  1  one-cycle pulse on an illegal read.

Behaviour:
- Reset (asynchronous, active-high):
  - Both banks EMPTY; wr_bank=0, rd_bank=0, wr_ptr=0.
  - All outputs 0.
  - RAM contents are not cleared.
  - Reset asserted mid-fill or mid-read aborts the operation: a partial fill is discarded and no bank_filled pulse is issued.
- Per-bank state is EMPTY, FILLING or FULL.
  - EMPTY to FILLING: first accepted write to that bank.
  - FILLING to FULL: write of word len-1.
  - FULL to EMPTY: rd_release while the bank is rd_bank.
- Write side:
  - wr_ready = 1 when the bank at wr_bank is EMPTY or FILLING.
  - A word is accepted on wr_valid & wr_ready and written at wr_ptr of wr_bank.
  - On the first accepted word of a bank, len = fill_len, clamped: 0 or >DEPTH becomes DEPTH. This word uses the freshly clamped value.
  - On the word with wr_ptr == len-1:
    - the bank becomes FULL and len is stored as that bank's length;
    - bank_filled pulses the next cycle;
    - wr_ptr returns to 0 and wr_bank toggles.
  - If the next bank is still FULL, wr_ready drops until that bank is released.
- Read side:
  - rd_bank_ready = 1 when the bank at rd_bank is FULL; rd_len is that bank's stored length (0 when not ready).
  - Accepted read is rd_en & rd_bank_ready & (rd_addr < rd_len):
    - rd_data is updated the next cycle and rd_valid=1 for that one cycle;
    - latency is exactly 1; back-to-back reads give one word per cycle.
  - Illegal read is rd_en with no ready bank or rd_addr ≥ rd_len:
    - rd_err pulses the next cycle;
    - rd_valid=0 and rd_data holds its previous value.
  - rd_release while rd_bank_ready:
    - the bank becomes EMPTY the next cycle and rd_bank toggles;
    - a read accepted in the same cycle still completes.
  - rd_release without rd_bank_ready is ignored.
- Simultaneous events:
  - Release of bank A and fill completion of bank B in the same cycle are both honoured. The next cycle shows rd_bank=B with rd_bank_ready=1, and A is EMPTY and writable.
  - If the writer is blocked on bank A and A is released, wr_ready rises the cycle after the release.
- Throughput:
  - Both sides proceed concurrently when different banks are involved.
  - Steady state needs no bubbles, provided the consumer releases before the producer finishes the next fill.

Decomposition:
- Package input_buffer_pkg:
  - bank_state_t enum {BANK_EMPTY, BANK_FILLING, BANK_FULL};
  - NUM_BANKS=2 constant;
  - function clamp_len(len, depth).
- Sub-module buffer_bank:
  - one simple dual-port RAM of DEPTH×BUFFER_DATA_WIDTH;
  - synchronous write, registered read;
  - instantiated twice, bank select via generate.
- The top level holds the bank state, pointers, lengths and handshake logic.

Test Plan:
1. Reset, then fill_len=4 and stream 10,-3,7,127 → bank_filled pulses once. rd_bank_ready=1 and rd_len=4. Reads at addresses 0..3 return 10,-3,7,127, each one cycle after rd_en, with rd_valid high.
2. Fill bank0 (len 4) and bank1 (len 4) with no release → wr_ready=0 after the 8th word. Release bank0 → wr_ready=1 the next cycle, and reads now return bank1 data.
3. fill_len=0 → clamped to DEPTH. Exactly 64 words are needed before bank_filled; rd_len=64.
4. rd_en with addr 5 when rd_len=4, and rd_en with no ready bank → rd_err pulse each time. rd_valid=0 and rd_data unchanged.
5. Release bank0 in the same cycle bank1 completes → next cycle rd_bank_ready=1, reads return bank1 words, and the writer immediately refills bank0.
6. Assert rst after 2 of 4 words → wr_ready, rd_bank_ready, rd_valid and rd_data all 0. The next full fill starts at address 0 and reads back correct values.
